// File: rtl/npc_lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and byte-strobe generation.
package npc_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    BUS_REQ,
    BUS_WAIT,
    RESP
  } state_e;

  // Byte strobe for an access of (1 << size) bytes starting at byte lane off.
  function automatic logic [7:0] gen_strb(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] w_mask;
    w_mask = ((16'd1 << (4'd1 << size)) - 16'd1) << off;
    return w_mask[7:0];
  endfunction

endpackage

// File: rtl/npc_lsu_extract.sv
// Load data lane select: shifts the addressed bytes down to bit 0 and zero- or
// sign-extends them to the full bus width.
module npc_lsu_extract import npc_lsu_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_shift;
  logic              w_msb;
  logic              w_fill;
  int                w_nbits;

  always_comb begin
    w_shift = i_data >> {i_off, 3'b000};
    unique case (i_size)
      SZ_B:    w_msb = w_shift[7];
      SZ_H:    w_msb = w_shift[15];
      SZ_W:    w_msb = w_shift[31];
      default: w_msb = w_shift[DATA_W-1];
    endcase
    w_nbits = 8 << i_size;
    if (w_nbits > DATA_W) w_nbits = DATA_W;
    w_fill = w_msb & ~i_unsigned;
    o_data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      o_data[i] = (i < w_nbits) ? w_shift[i] : w_fill;
    end
  end

endmodule

// File: rtl/npc_lsu.sv
// Single-outstanding load/store unit bridging the core request port to a
// NB-aligned memory bus. Optional macro NPC_LSU_MISALIGN_TRAP_EN faults
// misaligned accesses instead of aligning them down.
module npc_lsu import npc_lsu_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [1:0]          i_req_size,
  input  logic                i_req_unsigned,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W-1:0]   i_req_wdata,
  output logic                o_resp_valid,
  input  logic                i_resp_ready,
  output logic [DATA_W-1:0]   o_resp_rdata,
  output logic                o_resp_err,
  output logic                o_mem_req_valid,
  input  logic                i_mem_req_ready,
  output logic                o_mem_req_we,
  output logic [ADDR_W-1:0]   o_mem_req_addr,
  output logic [DATA_W-1:0]   o_mem_req_wdata,
  output logic [DATA_W/8-1:0] o_mem_req_wstrb,
  input  logic                i_mem_resp_valid,
  input  logic [DATA_W-1:0]   i_mem_resp_rdata,
  input  logic                i_mem_resp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  state_e            r_state;
  logic              r_req_ready;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [OFF_W-1:0]  r_off;
  logic              r_mem_req_valid;
  logic              r_mem_req_we;
  logic [ADDR_W-1:0] r_mem_req_addr;
  logic [DATA_W-1:0] r_mem_req_wdata;
  logic [NB-1:0]     r_mem_req_wstrb;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;

  logic [OFF_W-1:0]  w_off;
  logic [OFF_W-1:0]  w_off_use;
  logic [3:0]        w_lowmask;
  logic              w_illegal;
  logic              w_skip;
  logic [NB-1:0]     w_wstrb;
  logic [DATA_W-1:0] w_wdata;
  logic [ADDR_W-1:0] w_addr_al;
  logic [DATA_W-1:0] w_ext;

  assign w_off     = i_req_addr[OFF_W-1:0];
  assign w_lowmask = (4'd1 << i_req_size) - 4'd1;
  assign w_illegal = (DATA_W == 32) && (i_req_size == SZ_D);

`ifdef NPC_LSU_MISALIGN_TRAP_EN
  assign w_off_use = w_off;
  assign w_skip    = w_illegal | (|(w_off & w_lowmask[OFF_W-1:0]));
`else
  assign w_off_use = w_off & ~w_lowmask[OFF_W-1:0];
  assign w_skip    = w_illegal;
`endif

  assign w_wstrb   = NB'(gen_strb(i_req_size, 3'(w_off_use)));
  assign w_wdata   = i_req_wdata << {w_off_use, 3'b000};
  assign w_addr_al = {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  npc_lsu_extract #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_extract (
    .i_data     (i_mem_resp_rdata),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_req_ready     <= 1'b1;
      r_we            <= 1'b0;
      r_size          <= SZ_B;
      r_unsigned      <= 1'b0;
      r_off           <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_we    <= 1'b0;
      r_mem_req_addr  <= '0;
      r_mem_req_wdata <= '0;
      r_mem_req_wstrb <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_rdata    <= '0;
      r_resp_err      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_req_ready <= 1'b0;
            r_we        <= i_req_we;
            r_size      <= i_req_size;
            r_unsigned  <= i_req_unsigned;
            r_off       <= w_off_use;
            if (w_skip) begin
              // Faulting access never reaches the bus.
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state         <= BUS_REQ;
              r_mem_req_valid <= 1'b1;
              r_mem_req_we    <= i_req_we;
              r_mem_req_addr  <= w_addr_al;
              r_mem_req_wdata <= i_req_we ? w_wdata : '0;
              r_mem_req_wstrb <= i_req_we ? w_wstrb : '0;
            end
          end
        end
        BUS_REQ: begin
          if (i_mem_req_ready) begin
            r_state         <= BUS_WAIT;
            r_mem_req_valid <= 1'b0;
            r_mem_req_we    <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_wdata <= '0;
            r_mem_req_wstrb <= '0;
          end
        end
        BUS_WAIT: begin
          if (i_mem_resp_valid) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= i_mem_resp_err;
            r_resp_rdata <= (i_mem_resp_err || r_we) ? '0 : w_ext;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready     = r_req_ready;
  assign o_mem_req_valid = r_mem_req_valid;
  assign o_mem_req_we    = r_mem_req_we;
  assign o_mem_req_addr  = r_mem_req_addr;
  assign o_mem_req_wdata = r_mem_req_wdata;
  assign o_mem_req_wstrb = r_mem_req_wstrb;
  assign o_resp_valid    = r_resp_valid;
  assign o_resp_rdata    = r_resp_rdata;
  assign o_resp_err      = r_resp_err;

endmodule

// File: tb/tb_npc_lsu.sv
// Bench for npc_lsu: directed cases plus randomized accesses checked against
// an arithmetic byte-lane model; a second 64-bit instance covers wide lanes.
module tb_npc_lsu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 32-bit instance
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid, mem_resp_err;
  logic [31:0] mem_resp_rdata;

  npc_lsu #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk              (clk),
    .reset            (reset),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_we         (req_we),
    .i_req_size       (req_size),
    .i_req_unsigned   (req_unsigned),
    .i_req_addr       (req_addr),
    .i_req_wdata      (req_wdata),
    .o_resp_valid     (resp_valid),
    .i_resp_ready     (resp_ready),
    .o_resp_rdata     (resp_rdata),
    .o_resp_err       (resp_err),
    .o_mem_req_valid  (mem_req_valid),
    .i_mem_req_ready  (mem_req_ready),
    .o_mem_req_we     (mem_req_we),
    .o_mem_req_addr   (mem_req_addr),
    .o_mem_req_wdata  (mem_req_wdata),
    .o_mem_req_wstrb  (mem_req_wstrb),
    .i_mem_resp_valid (mem_resp_valid),
    .i_mem_resp_rdata (mem_resp_rdata),
    .i_mem_resp_err   (mem_resp_err)
  );

  // 64-bit instance
  logic        req_valid64, req_ready64, req_we64, req_unsigned64;
  logic [1:0]  req_size64;
  logic [31:0] req_addr64;
  logic [63:0] req_wdata64;
  logic        resp_valid64, resp_ready64, resp_err64;
  logic [63:0] resp_rdata64;
  logic        mem_req_valid64, mem_req_ready64, mem_req_we64;
  logic [31:0] mem_req_addr64;
  logic [63:0] mem_req_wdata64;
  logic [7:0]  mem_req_wstrb64;
  logic        mem_resp_valid64, mem_resp_err64;
  logic [63:0] mem_resp_rdata64;

  npc_lsu #(.ADDR_W(32), .DATA_W(64)) u_dut64 (
    .clk              (clk),
    .reset            (reset),
    .i_req_valid      (req_valid64),
    .o_req_ready      (req_ready64),
    .i_req_we         (req_we64),
    .i_req_size       (req_size64),
    .i_req_unsigned   (req_unsigned64),
    .i_req_addr       (req_addr64),
    .i_req_wdata      (req_wdata64),
    .o_resp_valid     (resp_valid64),
    .i_resp_ready     (resp_ready64),
    .o_resp_rdata     (resp_rdata64),
    .o_resp_err       (resp_err64),
    .o_mem_req_valid  (mem_req_valid64),
    .i_mem_req_ready  (mem_req_ready64),
    .o_mem_req_we     (mem_req_we64),
    .o_mem_req_addr   (mem_req_addr64),
    .o_mem_req_wdata  (mem_req_wdata64),
    .o_mem_req_wstrb  (mem_req_wstrb64),
    .i_mem_resp_valid (mem_resp_valid64),
    .i_mem_resp_rdata (mem_resp_rdata64),
    .i_mem_resp_err   (mem_resp_err64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: byte-lane arithmetic on a 4-byte bus.
  task automatic model(input bit we, input bit [1:0] size, input bit uns, input bit [31:0] addr,
                       input bit [31:0] wdata, input bit [31:0] bus, output bit skip,
                       output bit [31:0] e_addr, output bit [31:0] e_wdata,
                       output bit [3:0] e_strb, output bit [31:0] e_load);
    int bytes;
    int off;
    bit [63:0] v;
    bytes = 1 << size;
    off   = int'(addr % 4);
    skip  = (bytes > 4);
`ifdef NPC_LSU_MISALIGN_TRAP_EN
    if (off % bytes != 0) skip = 1'b1;
`else
    off = off - (off % bytes);
`endif
    e_addr  = addr - (addr % 4);
    v       = 64'(wdata) << (8 * off);
    e_wdata = we ? v[31:0] : 32'd0;
    v       = ((64'd1 << bytes) - 64'd1) << off;
    e_strb  = we ? v[3:0] : 4'd0;
    v = (64'(bus) >> (8 * off)) & ((64'd1 << (8 * bytes)) - 64'd1);
    if (!uns && ((v >> (8 * bytes - 1)) & 64'd1) == 64'd1) v = v - (64'd1 << (8 * bytes));
    e_load = v[31:0];
  endtask

  task automatic run(input bit we, input bit [1:0] size, input bit uns, input bit [31:0] addr,
                     input bit [31:0] wdata, input bit [31:0] bus, input bit berr,
                     input int mdly, input int rdly);
    bit        skip;
    bit [31:0] e_addr, e_wdata, e_load, e_rdata;
    bit [3:0]  e_strb;
    bit        e_err;
    model(we, size, uns, addr, wdata, bus, skip, e_addr, e_wdata, e_strb, e_load);
    check("idle_req_ready", req_ready, 1);
    check("idle_mem_req_valid", mem_req_valid, 0);
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
    check("busy_req_ready", req_ready, 0);
    if (skip) begin
      check("skip_mem_req_valid", mem_req_valid, 0);
      e_err = 1; e_rdata = 0;
    end else begin
      for (int k = 0; k <= mdly; k++) begin
        check("mem_req_valid", mem_req_valid, 1);
        check("mem_req_we", mem_req_we, we);
        check("mem_req_addr", mem_req_addr, e_addr);
        check("mem_req_wstrb", mem_req_wstrb, e_strb);
        if (we) check("mem_req_wdata", mem_req_wdata, e_wdata);
        check("bus_req_resp_valid", resp_valid, 0);
        // Stray bus responses while the request is still pending must be ignored.
        mem_resp_valid = (k < mdly); mem_resp_rdata = $urandom; mem_resp_err = 1'b1;
        mem_req_ready = (k == mdly);
        tick();
      end
      mem_req_ready = 0; mem_resp_valid = 0;
      check("wait_mem_req_valid", mem_req_valid, 0);
      check("wait_resp_valid", resp_valid, 0);
      mem_resp_valid = 1; mem_resp_rdata = bus; mem_resp_err = berr;
      tick();
      mem_resp_valid = 0; mem_resp_rdata = $urandom; mem_resp_err = 0;
      e_err   = berr;
      e_rdata = (berr || we) ? 32'd0 : e_load;
    end
    for (int k = 0; k <= rdly; k++) begin
      check("resp_valid", resp_valid, 1);
      check("resp_err", resp_err, e_err);
      check("resp_rdata", resp_rdata, e_rdata);
      resp_ready = (k == rdly);
      tick();
    end
    resp_ready = 0;
    check("done_resp_valid", resp_valid, 0);
    check("done_resp_rdata", resp_rdata, 0);
    check("done_req_ready", req_ready, 1);
  endtask

  task automatic run64(input bit we, input bit [1:0] size, input bit uns, input bit [31:0] addr,
                       input bit [63:0] wdata, input bit [63:0] bus, input bit [31:0] e_addr,
                       input bit [63:0] e_wdata, input bit [7:0] e_strb,
                       input bit [63:0] e_rdata);
    req_valid64 = 1; req_we64 = we; req_size64 = size; req_unsigned64 = uns;
    req_addr64 = addr; req_wdata64 = wdata;
    tick();
    req_valid64 = 0;
    check("w64_mem_req_valid", mem_req_valid64, 1);
    check("w64_mem_req_addr", mem_req_addr64, e_addr);
    check("w64_mem_req_wstrb", mem_req_wstrb64, e_strb);
    if (we) check("w64_mem_req_wdata", mem_req_wdata64, e_wdata);
    mem_req_ready64 = 1;
    tick();
    mem_req_ready64 = 0; mem_resp_valid64 = 1; mem_resp_rdata64 = bus;
    tick();
    mem_resp_valid64 = 0;
    check("w64_resp_valid", resp_valid64, 1);
    check("w64_resp_err", resp_err64, 0);
    check("w64_resp_rdata", resp_rdata64, e_rdata);
    resp_ready64 = 1;
    tick();
    resp_ready64 = 0;
    check("w64_req_ready", req_ready64, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0; mem_resp_err = 0;
    req_valid64 = 0; req_we64 = 0; req_size64 = 0; req_unsigned64 = 0; req_addr64 = 0;
    req_wdata64 = 0; resp_ready64 = 0; mem_req_ready64 = 0; mem_resp_valid64 = 0;
    mem_resp_rdata64 = 0; mem_resp_err64 = 0;
    tick();
    tick();
    reset = 0;
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_req_wstrb", mem_req_wstrb, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);

    // Byte store into the top lane
    run(1, 2'd0, 0, 32'h8000_0003, 32'h0000_00A5, 32'h0, 0, 0, 0);
    // Signed and unsigned byte loads from lane 1
    run(0, 2'd0, 0, 32'h8000_0001, 32'h0, 32'h0000_8000, 0, 0, 0);
    run(0, 2'd0, 1, 32'h8000_0001, 32'h0, 32'h0000_8000, 0, 0, 0);
    // Misaligned half: faults or aligns down depending on the build
    run(0, 2'd1, 0, 32'h8000_0001, 32'h0, 32'h1234_8765, 0, 0, 0);
    // Slow bus grant, bus error, response back-pressure
    run(0, 2'd2, 0, 32'h8000_0000, 32'h0, 32'hCAFE_F00D, 1, 5, 3);
    // Dword on a 32-bit bus is illegal
    run(0, 2'd3, 0, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 1);

    for (int n = 0; n < 40; n++) begin
      run(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
          ($urandom % 5) == 0, int'($urandom % 4), int'($urandom % 3));
    end

    // Reset while waiting for the bus response, then a late response arrives
    req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h8000_0010;
    tick();
    req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    reset = 1;
    tick();
    reset = 0;
    check("rst_wait_req_ready", req_ready, 1);
    check("rst_wait_mem_req_valid", mem_req_valid, 0);
    check("rst_wait_resp_valid", resp_valid, 0);
    mem_resp_valid = 1; mem_resp_rdata = 32'h1234_5678;
    tick();
    mem_resp_valid = 0;
    check("stray_resp_valid", resp_valid, 0);
    check("stray_req_ready", req_ready, 1);
    tick();
    check("stray_resp_valid_later", resp_valid, 0);

    // Reset while the bus request is still pending
    req_valid = 1; req_size = 2'd2; req_addr = 32'h8000_0020;
    tick();
    req_valid = 0;
    check("pre_rst_mem_req_valid", mem_req_valid, 1);
    reset = 1;
    tick();
    reset = 0;
    check("rst_req_mem_req_valid", mem_req_valid, 0);
    check("rst_req_mem_req_addr", mem_req_addr, 0);
    check("rst_req_req_ready", req_ready, 1);
    run(0, 2'd2, 1, 32'h8000_0024, 32'h0, 32'h89AB_CDEF, 0, 0, 0);

    // 64-bit bus lanes
    run64(0, 2'd2, 1, 32'h8000_0004, 64'h0, 64'hDEAD_BEEF_0000_0000, 32'h8000_0000,
          64'h0, 8'h00, 64'h0000_0000_DEAD_BEEF);
    run64(0, 2'd1, 0, 32'h8000_0006, 64'h0, 64'h8001_0000_0000_0000, 32'h8000_0000,
          64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_8001);
    run64(1, 2'd3, 0, 32'h8000_0008, 64'h1122_3344_5566_7788, 64'h0, 32'h8000_0008,
          64'h1122_3344_5566_7788, 8'hFF, 64'h0);
    run64(1, 2'd1, 0, 32'h8000_0002, 64'h0000_0000_0000_BEEF, 64'h0, 32'h8000_0000,
          64'h0000_0000_BEEF_0000, 8'h0C, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
